mem_bus_arbiter: RTL and testbench

- Shares the single DataMemory bus (address, write data, read data, byte-mode strobes) between up to NREQ masters: the CPU, plus a future DMA engine and the host client port.
- Each master raises req and drives the bus only while its grt is high; the CPU gates its bus buffers off the same grant.
- Round-robin, grant held until the owner releases, one-cycle turnaround between owners so tristated drivers never overlap.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory-bus arbiter and its round-robin picker:
// state encoding and default sizing.
package arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_TURN  = 2'd2;

  localparam int DEFAULT_NREQ     = 4;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_GRANT = ARB_GRANT,
    ST_TURN  = ARB_TURN
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning circularly from i_ptr+1, plus a valid flag when any bit is set.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int W   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [W-1:0]    i_ptr,
  output logic [W-1:0]    o_winner,
  output logic            o_valid
);

  logic [W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest set request is written last.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = W'((int'(i_ptr) + i) % NREQ);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end else begin
        o_winner = o_winner;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner-holds arbiter for the shared DataMemory bus, with a
// one-cycle turnaround between owners. Define ARB_TIMEOUT_EN to add forced
// revocation after MAX_HOLD grant cycles when another master is waiting.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = DEFAULT_NREQ,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int W       = $clog2(NREQ)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grt,
  output logic [W-1:0]    owner,
  output logic            busy,
  output logic            timeout_evt
);

  arb_state_e      r_state, w_state;
  logic [NREQ-1:0] r_grt, w_grt;
  logic [W-1:0]    r_owner, w_owner;
  logic [W-1:0]    r_ptr, w_ptr;
  logic            r_busy;
  logic [W-1:0]    w_winner;
  logic            w_valid;
  logic [NREQ-1:0] w_onehot;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  logic [HW-1:0] r_hold, w_hold;
  logic          r_tevt, w_tevt;
`endif

  rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

  // Next-state, grant and pointer decisions.
  always_comb begin
    w_state = r_state;
    w_grt   = r_grt;
    w_owner = r_owner;
    w_ptr   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_hold  = r_hold;
    w_tevt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_TURN: begin
        if (w_valid) begin
          w_grt   = w_onehot;
          w_owner = w_winner;
          w_ptr   = w_winner;
          w_state = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          w_hold  = '0;
`endif
        end else begin
          w_grt   = '0;
          w_state = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[r_owner]) begin
          w_grt   = '0;
          w_state = ST_TURN;
        end
`ifdef ARB_TIMEOUT_EN
        // Revoke only when someone else is actually waiting for the bus.
        else if ((r_hold == HOLD_MAX) && ((req & ~r_grt) != '0)) begin
          w_grt   = '0;
          w_tevt  = 1'b1;
          w_state = ST_TURN;
        end else begin
          w_state = ST_GRANT;
          if (r_hold != HOLD_MAX) begin
            w_hold = r_hold + HW'(1);
          end else begin
            w_hold = r_hold;
          end
        end
`else
        else begin
          w_state = ST_GRANT;
        end
`endif
      end
      default: begin
        w_grt   = '0;
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_grt   <= '0;
      r_owner <= '0;
      r_ptr   <= W'(NREQ - 1);
      r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= '0;
      r_tevt  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_grt   <= w_grt;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_busy  <= |w_grt;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= w_hold;
      r_tevt  <= w_tevt;
`endif
    end
  end

  assign grt   = r_grt;
  assign owner = r_owner;
  assign busy  = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign timeout_evt = r_tevt;
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (NREQ=4, MAX_HOLD=8);
// expectations for the revocation scenario depend on ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] req;
  logic [3:0] grt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout_evt;

  int checks;
  int errors;

  mem_bus_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .req         (req),
    .grt         (grt),
    .owner       (owner),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (grt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grt=%b busy=%b owner=%0d tevt=%b, required 0000/0/0/0",
               grt, busy, owner, timeout_evt);
    end
    Rst = 1'b0;
    tick();
    checks++;
    if (grt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: grt=%b owner=%0d busy=%b, required 0001/0/1",
               grt, owner, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_turn: grt=%b busy=%b, required 0000/0", grt, busy);
    end
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold[%0d]: grt=%b owner=%0d busy=%b, required 0100/2/1",
                 c, grt, owner, busy);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd2) begin
      errors++;
      $display("FAIL single_turn: grt=%b busy=%b owner=%0d, required 0000/0/2", grt, busy, owner);
    end
    tick();
    checks++;
    if (grt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: grt=%b busy=%b, required 0000/0", grt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grt;
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grt = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (grt !== exp_grt || owner !== 2'(k % 4) || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant[%0d.%0d]: grt=%b owner=%0d busy=%b, required %b/%0d/1",
                   k, c, grt, owner, busy, exp_grt, k % 4);
        end
      end
      req[k % 4] = 1'b0;
      tick();
      checks++;
      if (grt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_turn[%0d]: grt=%b busy=%b, required 0000/0", k, grt, busy);
      end
      req[k % 4] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (grt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL arst_setup: grt=%b owner=%0d, required 0100/2", grt, owner);
    end
    tick();
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (grt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL arst_immediate: grt=%b busy=%b owner=%0d, required 0000/0/0",
               grt, busy, owner);
    end
    req = 4'b1010;
    tick();
    Rst = 1'b0;
    tick();
    checks++;
    if (grt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_lowest_pending: grt=%b owner=%0d busy=%b, required 0010/1/1",
               grt, owner, busy);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    pulse_reset();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 2) req = 4'b0011;
      checks++;
      if (grt !== 4'b0001 || timeout_evt !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold[%0d]: grt=%b tevt=%b, required 0001/0", c, grt, timeout_evt);
      end
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (grt !== 4'b0000 || timeout_evt !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_revoke: grt=%b tevt=%b busy=%b, required 0000/1/0",
               grt, timeout_evt, busy);
    end
    tick();
    checks++;
    if (grt !== 4'b0010 || timeout_evt !== 1'b0 || owner !== 2'd1) begin
      errors++;
      $display("FAIL tmo_next_owner: grt=%b tevt=%b owner=%0d, required 0010/0/1",
               grt, timeout_evt, owner);
    end
`else
    checks++;
    if (grt !== 4'b0001 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL tmo_disabled_hold: grt=%b tevt=%b, required 0001/0", grt, timeout_evt);
    end
    tick();
    checks++;
    if (grt !== 4'b0001 || timeout_evt !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL tmo_disabled_owner: grt=%b tevt=%b owner=%0d, required 0001/0/0",
               grt, timeout_evt, owner);
    end
`endif
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_no_competitor();
    pulse_reset();
    req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (grt !== 4'b0001 || timeout_evt !== 1'b0) begin
        errors++;
        $display("FAIL solo_hold[%0d]: grt=%b tevt=%b, required 0001/0", c, grt, timeout_evt);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grt !== 4'b0000 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL solo_release: grt=%b tevt=%b, required 0000/0", grt, timeout_evt);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_async_reset();
    test_timeout();
    test_no_competitor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
